// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer that stalls EX until the result is ready
module muldiv_seq #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, next;

  logic [2:0]        op_r;
  logic              neg_r;
  logic [CW-1:0]     count;
  logic [XLEN-1:0]   dvsr;
  logic [2*XLEN-1:0] acc;

  logic              accept, is_div, a_sgn, b_sgn, a_neg, b_neg, b_zero;
  logic              div_zero, ovf, early, sgn;
  logic [XLEN-1:0]   a_mag, b_mag, early_res;
  logic [XLEN:0]     add, rs, diff;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, acc_nxt, fin_p;
  logic [XLEN-1:0]   mul_res, dres, div_res, fin;

  // Operand decode at acceptance: magnitudes, final sign and the early-out shortcuts.
  // A zero divisor never flips the quotient sign so the iterated path still yields all ones.
  always_comb begin
    accept    = (state == IDLE) && start && !flush;
    is_div    = op[2];
    a_sgn     = (op == 3'd1) || (op == 3'd2) || (op[2] && !op[0]);
    b_sgn     = (op == 3'd1) || (op[2] && !op[0]);
    a_neg     = a_sgn && a[XLEN-1];
    b_neg     = b_sgn && b[XLEN-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    b_zero    = (b == '0);
    div_zero  = EARLY_OUT && is_div && b_zero;
    ovf       = EARLY_OUT && is_div && !op[0] && (a == MIN_INT) && (b == '1);
    early     = div_zero || ovf;
    sgn       = is_div ? (op[1] ? a_neg : (a_neg ^ b_neg) && !b_zero) : (a_neg ^ b_neg);
    early_res = op[1] ? (div_zero ? a : '0) : (div_zero ? '1 : a);
  end

  // One radix-2 step: shift-add multiply or restoring divide, plus final sign fix and select.
  always_comb begin
    add     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dvsr} : '0);
    mul_nxt = {add, acc[XLEN-1:1]};
    rs      = acc[2*XLEN-1:XLEN-1];
    diff    = rs - {1'b0, dvsr};
    div_nxt = diff[XLEN] ? {rs[XLEN-1:0], acc[XLEN-2:0], 1'b0} : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    acc_nxt = op_r[2] ? div_nxt : mul_nxt;
    fin_p   = neg_r ? -acc_nxt : acc_nxt;
    mul_res = (op_r == 3'd0) ? fin_p[XLEN-1:0] : fin_p[2*XLEN-1:XLEN];
    dres    = op_r[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
    div_res = neg_r ? -dres : dres;
    fin     = op_r[2] ? div_res : mul_res;
  end

  // Next state: flush always returns to IDLE; DONE always falls back to IDLE.
  always_comb begin
    next  = flush ? IDLE
          : (state == IDLE) ? (start ? (early ? DONE : CALC) : IDLE)
          : (state == CALC) ? ((count == CW'(1)) ? DONE : CALC)
          : IDLE;
    stall = accept || ((state == CALC) && !flush);
  end

  // State register with registered busy/done status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next;
      busy  <= (next != IDLE);
      done  <= (next == DONE);
    end
  end

  // Datapath: latch operands on accept, iterate in CALC, register the result on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r   <= '0;
      neg_r  <= 1'b0;
      count  <= '0;
      dvsr   <= '0;
      acc    <= '0;
      result <= '0;
    end else if (accept) begin
      op_r  <= op;
      neg_r <= sgn;
      count <= CW'(XLEN);
      dvsr  <= is_div ? b_mag : a_mag;
      acc   <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
      if (early) result <= early_res;
    end else if ((state == CALC) && !flush) begin
      acc   <= acc_nxt;
      count <= count - CW'(1);
      if (count == CW'(1)) result <= fin;
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed-vector scoreboard bench for muldiv_seq
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        stall, busy, done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_done = 0;
  logic [31:0] last_exp = '0;

  muldiv_seq #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=0x%08h exp=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done act=1 exp=0 cyc=%0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("done_cycle", 32'(cyc), 32'(e.due));
        last_done = cyc;
      end
    end
  end

  // Issue one op at cycle N (called #1 after a posedge), hold start through DONE.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input bit is_early);
    int n, st, k;
    start = 1'b1; op = o; a = x; b = y;
    n = cyc;
    sb.push_back('{res: exp, due: n + (is_early ? 1 : 33)});
    last_exp = exp;
    st = 0;
    k = 0;
    do begin
      @(negedge clk);
      if (stall) st++;
      k++;
    end while (!done && k < 40);
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    chk("stall_cycles", 32'(st), is_early ? 32'd1 : 32'd33);
    @(posedge clk); #1;
  endtask

  initial begin
    int t1;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_stall", {31'd0, stall}, 32'd0);
    issue(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 0);
    issue(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 0);
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    issue(3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 0);
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0);
    issue(3'd3, 32'h80000000, 32'd4, 32'h00000002, 0);
    issue(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 0);
    issue(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 0);
    issue(3'd5, 32'd100, 32'd7, 32'd14, 0);
    issue(3'd7, 32'd100, 32'd7, 32'd2, 0);
    issue(3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 0);
    issue(3'd6, 32'd7, 32'hFFFFFFFE, 32'd1, 0);
    issue(3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    issue(3'd6, 32'd5, 32'd0, 32'd5, 1);
    issue(3'd4, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 1);
    issue(3'd6, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1);
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
    repeat (10) @(posedge clk);
    #1;
    chk("calc_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1; start = 1'b0;
    #1;
    chk("flush_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_result", result, last_exp);
    flush = 1'b1; start = 1'b1; op = 3'd5; a = 32'd5; b = 32'd0;
    #1;
    chk("flush_start_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("flush_result_hold", result, last_exp);
    issue(3'd0, 32'd3, 32'd4, 32'd12, 0);
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0; start = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(3'd5, 32'd100, 32'd10, 32'd10, 0);
    t1 = last_done;
    issue(3'd7, 32'd100, 32'd30, 32'd10, 0);
    chk("b2b_spacing", 32'(last_done - t1), 32'd34);
    start = 1'b0;
    repeat (5) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
